// File: rtl/trng_entropy_sampler.sv
// Entropy front end: synchroniser, prescaled sampling, von Neumann extractor,
// repetition health test and word packer with a valid/ready output.
module trng_entropy_sampler #(
  parameter int WIDTH      = 5,
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_bit,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic {FIRST, SECOND} ext_t;

  logic             sync1;
  logic             s;
  logic [PW-1:0]    pcnt;
  logic             strobe;
  logic             prev;
  logic [RW-1:0]    rep_cnt;
  ext_t             state;
  logic             a;
  logic             emit;
  logic             take;
  logic             done;
  logic             xfer;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    bcnt;
  logic             full;

  assign strobe = (pcnt == PW'(SAMPLE_DIV - 1));
  assign emit   = strobe && (state == SECOND) && (a != s);
  assign take   = emit && !full && !health_fail;
  assign word   = {acc[WIDTH-2:0], a};
  assign done   = take && (bcnt == CW'(WIDTH - 1));
  assign xfer   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw_bit;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (strobe) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // rep_cnt saturates so a stuck source cannot wrap back below the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= 1'b0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else begin
      if (rep_cnt == RW'(REP_LIMIT)) begin
        health_fail <= 1'b1;
      end
      if (strobe) begin
        prev <= s;
        if (s != prev) begin
          rep_cnt <= RW'(1);
        end else if (rep_cnt != RW'(REP_LIMIT)) begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FIRST;
      a     <= 1'b0;
    end else if (strobe) begin
      unique case (state)
        FIRST: begin
          a     <= s;
          state <= SECOND;
        end
        SECOND: begin
          state <= FIRST;
        end
      endcase
    end
  end

  // acc doubles as the holding slot when a word completes under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      bcnt      <= '0;
      full      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (take) begin
        acc  <= word;
        bcnt <= bcnt + 1'b1;
      end
      if (done) begin
        bcnt <= '0;
        if (!out_valid || xfer) begin
          out_data  <= word;
          out_valid <= 1'b1;
        end else begin
          full <= 1'b1;
        end
      end else if (xfer) begin
        if (full) begin
          out_data <= acc;
          full     <= 1'b0;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_entropy_sampler.sv
// Scoreboard bench for trng_entropy_sampler: directed sample pairs plus
// random traffic against a sample-stream reference model.
module tb_trng_entropy_sampler;

  localparam int W   = 8;
  localparam int DIV = 1;
  localparam int LIM = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         raw_bit;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         health_fail;

  trng_entropy_sampler #(
    .WIDTH(W), .SAMPLE_DIV(DIV), .REP_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_bit(raw_bit),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit           hist[$];
  int           edge_idx;
  bit           have_first;
  bit           first_s;
  bit           prev_s;
  int           run;
  bit           hf_m;
  logic [W-1:0] partial;
  int           nbits;
  int           pending;
  logic [W-1:0] expq[$];

  logic [W-1:0] got[$];
  int           valid_cycles = 0;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endfunction

  function automatic void model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    edge_idx   = 0;
    have_first = 0;
    first_s    = 0;
    prev_s     = 0;
    run        = 0;
    hf_m       = 0;
    partial    = '0;
    nbits      = 0;
    pending    = 0;
    expq.delete();
  endfunction

  // one clock edge of the reference: sample stream lags raw by two edges
  function automatic void model_edge(bit r, bit rdy);
    bit hf_before = hf_m;
    bit xfer      = (pending > 0) && rdy;
    bit slots_out = (pending >= 2);
    bit smp;
    hist.push_back(r);
    smp = hist.pop_front();
    if (run >= LIM) hf_m = 1;
    if (edge_idx % DIV == DIV - 1) begin
      run    = (smp == prev_s) ? run + 1 : 1;
      prev_s = smp;
      if (!have_first) begin
        first_s    = smp;
        have_first = 1;
      end else begin
        have_first = 0;
        if (first_s != smp && !hf_before && !slots_out) begin
          partial = {partial[W-2:0], first_s};
          nbits++;
          if (nbits == W) begin
            expq.push_back(partial);
            pending++;
            nbits = 0;
          end
        end
      end
    end
    if (xfer) pending--;
    edge_idx++;
  endfunction

  always @(negedge clk) begin
    check("valid", {31'b0, out_valid}, (pending > 0) ? 1 : 0);
    check("health", {31'b0, health_fail}, {31'b0, hf_m});
    if (out_valid) begin
      valid_cycles++;
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL data: got %0h expected no word", out_data);
      end else begin
        check("data", {24'b0, out_data}, {24'b0, expq[0]});
        if (out_ready) begin
          got.push_back(out_data);
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic cyc(bit r, bit rdy);
    raw_bit   = r;
    out_ready = rdy;
    @(posedge clk);
    model_edge(r, rdy);
    #2;
  endtask

  task automatic pair(bit x, bit y, bit rdy);
    cyc(x, rdy);
    cyc(y, rdy);
  endtask

  task automatic send_word(logic [W-1:0] w, bit rdy);
    for (int i = W - 1; i >= 0; i--) begin
      pair(w[i], !w[i], rdy);
    end
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) pair(1'b0, 1'b0, rdy);
      else            pair(1'b1, 1'b1, rdy);
    end
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      raw_bit   = ~raw_bit;
      out_ready = 1'($urandom);
      @(negedge clk);
      check("rst_data", {24'b0, out_data}, 32'h0);
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
  endtask

  int base;
  int vbase;

  initial begin
    rst_n     = 1'b0;
    raw_bit   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #2;

    // 1: reset holds everything at zero while the source toggles
    do_reset(6);

    // 2: single word 0xB2 with a ready consumer
    base  = got.size();
    vbase = valid_cycles;
    send_word(8'hB2, 1'b1);
    idle(3, 1'b1);
    check("t2_count", got.size() - base, 1);
    check("t2_word", {24'b0, got[got.size()-1]}, 32'hB2);
    check("t2_vcyc", valid_cycles - vbase, 1);

    // 3: equal pairs emit nothing
    base = got.size();
    for (int i = 0; i < 7; i++) begin
      pair(1'b0, 1'b0, 1'b1);
      pair(1'b1, 1'b1, 1'b1);
    end
    check("t3_count", got.size() - base, 0);

    // 4: back-pressure, second word held, further bits lost
    base = got.size();
    send_word(8'hB2, 1'b0);
    send_word(8'h4D, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bit b = 1'($urandom);
      pair(b, !b, 1'b0);
    end
    check("t4_stall", {24'b0, out_data}, 32'hB2);
    idle(4, 1'b1);
    check("t4_count", got.size() - base, 2);
    check("t4_first", {24'b0, got[base]}, 32'hB2);
    check("t4_second", {24'b0, got[base+1]}, 32'h4D);

    // 5: stuck-at-one source trips the sticky health flag
    base = got.size();
    pair(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) pair(1'b1, 1'b1, 1'b1);
    check("t5_before", {31'b0, health_fail}, 32'h0);
    for (int i = 0; i < 3; i++) pair(1'b1, 1'b1, 1'b1);
    check("t5_trip", {31'b0, health_fail}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      bit b = 1'($urandom);
      pair(b, !b, 1'b1);
    end
    check("t5_sticky", {31'b0, health_fail}, 32'h1);
    check("t5_nowords", got.size() - base, 0);
    do_reset(1);
    check("t5_cleared", {31'b0, health_fail}, 32'h0);

    // 6: reset mid-word discards the partial word
    for (int i = 0; i < 5; i++) begin
      bit b = 1'($urandom);
      pair(b, !b, 1'b1);
    end
    base = got.size();
    do_reset(1);
    send_word(8'h5A, 1'b1);
    idle(3, 1'b1);
    check("t6_count", got.size() - base, 1);
    check("t6_word", {24'b0, got[base]}, 32'h5A);

    // random traffic with random back-pressure
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom), $urandom_range(0, 3) != 0);
    end
    idle(4, 1'b1);
    check("rand_drain", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
